// File: rtl/pong_ball_engine.sv
// -----------------------------------------------------------------------------
// pong_ball_engine
//
// Game-logic stage that sits in front of the VGA renderer. Once per frame it
// moves the ball and bounces it off the top and bottom walls and off both
// paddles. It detects misses, keeps the score, and runs the
// serve / play / game-over sequence.
//
// Ports
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   frame_tick   one-cycle pulse per frame (start of vertical blanking)
//   pos_l        left paddle centre row
//   pos_r        right paddle centre row
//   start        level input; restarts the game from the game-over state
//   ball_x       ball left column (0..639)
//   ball_y       ball top row (0..479)
//   ball_visible renderer draws the ball while high
//   score_l      left player score
//   score_r      right player score
//   game_over    high while the game-over state is active
// -----------------------------------------------------------------------------
module pong_ball_engine #(
    parameter int BALL_SIZE    = 4,
    parameter int SPEED_X      = 2,
    parameter int SPEED_Y      = 1,
    parameter int PADDLE_HALF  = 20,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [8:0] pos_l,
    input  logic [8:0] pos_r,
    input  logic       start,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       ball_visible,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [9:0]       CENTRE_X   = 10'd318;
    localparam logic [8:0]       CENTRE_Y   = 9'd238;
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);

    // Direction encodings: dx=1 means moving right, dy=1 means moving down.
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_UP    = 1'b0;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t           state;
    logic             dx;
    logic             dy;
    logic             serve_dy;
    logic [CNT_W-1:0] serve_cnt;

    // 11-bit views of the position so that sums and differences never wrap.
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    assign x_ext = {1'b0, ball_x};
    assign y_ext = {2'b00, ball_y};

    // The ball rows y..y+BALL_SIZE-1 overlap the paddle rows
    // p-(PADDLE_HALF-1)..p+(PADDLE_HALF-1). The lower bound is moved to the
    // ball side so that small paddle positions cannot underflow.
    function automatic logic overlap(input logic [10:0] y, input logic [8:0] p);
        logic [10:0] p_ext;
        p_ext = {2'b00, p};
        return (y + 11'(BALL_SIZE - 1 + PADDLE_HALF - 1) >= p_ext) &&
               (y <= p_ext + 11'(PADDLE_HALF - 1));
    endfunction

    // ---------------------------------------------------------------------
    // Vertical candidate: wall reflection is folded into the same step.
    // ---------------------------------------------------------------------
    logic [8:0] y_next;
    logic       dy_next;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        y_next  = ball_y;
        dy_next = dy;
        if (dy == DIR_DOWN) begin
            if (y_ext + 11'(SPEED_Y) >= 11'(480 - BALL_SIZE)) begin
                y_next  = 9'(480 - BALL_SIZE);
                dy_next = DIR_UP;
            end else begin
                y_next = ball_y + 9'(SPEED_Y);
            end
        end else begin
            if (y_ext <= 11'(SPEED_Y)) begin
                y_next  = 9'd0;
                dy_next = DIR_DOWN;
            end else begin
                y_next = ball_y - 9'(SPEED_Y);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Horizontal candidate: paddle hits take priority over misses.
    // The left paddle face is column 15, the right paddle face is column 625.
    // ---------------------------------------------------------------------
    logic       hit_l;
    logic       hit_r;
    logic       miss_l;   // ball left the field on the left: right player scores
    logic       miss_r;   // ball left the field on the right: left player scores
    logic [9:0] x_next;
    logic       dx_next;

    assign hit_l  = (dx == DIR_LEFT) &&
                    (x_ext >= 11'd16) &&
                    (x_ext - 11'(SPEED_X) <= 11'd15) &&
                    overlap(y_ext, pos_l);
    assign miss_l = (dx == DIR_LEFT) && !hit_l && (x_ext <= 11'(SPEED_X));

    assign hit_r  = (dx == DIR_RIGHT) &&
                    (x_ext + 11'(BALL_SIZE - 1) <= 11'd624) &&
                    (x_ext + 11'(SPEED_X + BALL_SIZE - 1) >= 11'd625) &&
                    overlap(y_ext, pos_r);
    assign miss_r = (dx == DIR_RIGHT) && !hit_r &&
                    (x_ext + 11'(SPEED_X) >= 11'(640 - BALL_SIZE));

    always_comb begin
        x_next  = (dx == DIR_RIGHT) ? ball_x + 10'(SPEED_X) : ball_x - 10'(SPEED_X);
        dx_next = dx;
        if (hit_l) begin
            x_next  = 10'd16;
            dx_next = DIR_RIGHT;
        end else if (hit_r) begin
            x_next  = 10'(625 - BALL_SIZE);
            dx_next = DIR_LEFT;
        end
    end

    logic [3:0] score_l_inc;
    logic [3:0] score_r_inc;
    assign score_l_inc = score_l + 4'd1;
    assign score_r_inc = score_r + 4'd1;

    // ---------------------------------------------------------------------
    // State machine and all registered outputs.
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so rst is just another
        // synchronous input and takes priority over all game logic.
        if (rst) begin
            state        <= SERVE;
            ball_x       <= CENTRE_X;
            ball_y       <= CENTRE_Y;
            dx           <= DIR_RIGHT;
            dy           <= DIR_DOWN;
            serve_dy     <= DIR_DOWN;
            serve_cnt    <= SERVE_LOAD;
            score_l      <= 4'd0;
            score_r      <= 4'd0;
            ball_visible <= 1'b1;
            game_over    <= 1'b0;
        end else begin
            case (state)
                SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt == '0) begin
                            state <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt - 1'b1;
                        end
                    end
                end

                PLAY: begin
                    if (frame_tick) begin
                        if (miss_l || miss_r) begin
                            // The vertical candidate is dropped on a point.
                            if (miss_r) begin
                                score_l <= score_l_inc;
                            end else begin
                                score_r <= score_r_inc;
                            end
                            if ((miss_r && score_l_inc == 4'(WIN_SCORE)) ||
                                (miss_l && score_r_inc == 4'(WIN_SCORE))) begin
                                // Ball stays where it was, hidden.
                                state        <= OVER;
                                ball_visible <= 1'b0;
                                game_over    <= 1'b1;
                            end else begin
                                // Serve toward the player who conceded.
                                state     <= SERVE;
                                ball_x    <= CENTRE_X;
                                ball_y    <= CENTRE_Y;
                                dx        <= miss_r ? DIR_RIGHT : DIR_LEFT;
                                dy        <= serve_dy;
                                serve_dy  <= ~serve_dy;
                                serve_cnt <= SERVE_LOAD;
                            end
                        end else begin
                            ball_x <= x_next;
                            dx     <= dx_next;
                            ball_y <= y_next;
                            dy     <= dy_next;
                        end
                    end
                end

                OVER: begin
                    // frame_tick is ignored here; only start leaves this state.
                    if (start) begin
                        state        <= SERVE;
                        ball_x       <= CENTRE_X;
                        ball_y       <= CENTRE_Y;
                        dx           <= DIR_RIGHT;
                        dy           <= DIR_DOWN;
                        serve_cnt    <= SERVE_LOAD;
                        score_l      <= 4'd0;
                        score_r      <= 4'd0;
                        ball_visible <= 1'b1;
                        game_over    <= 1'b0;
                    end
                end

                default: begin
                    state <= SERVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// -----------------------------------------------------------------------------
// tb_pong_ball_engine
//
// Scoreboard bench for pong_ball_engine. The driver issues frame ticks, start
// pulses and resets. For each one it advances a reference model of the game
// and queues the expected outputs. A separate monitor pops one entry after
// every such event. On every other cycle it checks that the outputs hold still.
// -----------------------------------------------------------------------------
module tb_pong_ball_engine;

    localparam int BALL   = 4;
    localparam int SPX    = 2;
    localparam int SPY    = 1;
    localparam int PH     = 20;
    localparam int SERVES = 60;
    localparam int WIN    = 9;

    // Paddle driving modes
    localparam int TRACK     = 0;  // paddle centred near the ball
    localparam int RAND      = 1;  // any 9-bit row
    localparam int FIXED     = 2;  // constant row
    localparam int EDGE_HIT  = 3;  // paddle top row == ball bottom row
    localparam int EDGE_MISS = 4;  // paddle top row one below ball bottom row

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [8:0] pos_l = 9'd0;
    logic [8:0] pos_r = 9'd0;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       ball_visible;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;

    always #5 clk = ~clk;

    pong_ball_engine dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .pos_l        (pos_l),
        .pos_r        (pos_r),
        .start        (start),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .ball_visible (ball_visible),
        .score_l      (score_l),
        .score_r      (score_r),
        .game_over    (game_over)
    );

    typedef struct {
        int x;
        int y;
        int vis;
        int sl;
        int sr;
        int go;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // ---------------------------------------------------------------------
    // Reference model: signed velocities and plain integer geometry.
    // ---------------------------------------------------------------------
    typedef enum {M_SERVE, M_PLAY, M_OVER} mstate_t;

    mstate_t m_state;
    int m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_vis, m_cnt, m_serve_vy;

    function automatic void model_reset();
        m_state    = M_SERVE;
        m_x        = 318;
        m_y        = 238;
        m_vx       = SPX;
        m_vy       = SPY;
        m_serve_vy = SPY;
        m_sl       = 0;
        m_sr       = 0;
        m_vis      = 1;
        m_cnt      = SERVES - 1;
    endfunction

    function automatic void model_restart();
        m_state = M_SERVE;
        m_x     = 318;
        m_y     = 238;
        m_vx    = SPX;
        m_vy    = SPY;
        m_sl    = 0;
        m_sr    = 0;
        m_vis   = 1;
        m_cnt   = SERVES - 1;
    endfunction

    // Ball rows [m_y, m_y+BALL-1] intersect paddle rows [p-(PH-1), p+(PH-1)].
    function automatic bit covers(int p);
        return (m_y + BALL - 1 >= p - (PH - 1)) && (m_y <= p + (PH - 1));
    endfunction

    function automatic void model_tick(int pl, int pr);
        int nx, ny, nvx, nvy;
        bit left_scores, right_scores;
        if (m_state == M_SERVE) begin
            if (m_cnt == 0) m_state = M_PLAY;
            else m_cnt--;
            return;
        end
        if (m_state != M_PLAY) return;

        ny  = m_y + m_vy;
        nvy = m_vy;
        if (ny <= 0) begin
            ny  = 0;
            nvy = SPY;
        end else if (ny >= 480 - BALL) begin
            ny  = 480 - BALL;
            nvy = -SPY;
        end

        nx  = m_x + m_vx;
        nvx = m_vx;
        left_scores  = 0;
        right_scores = 0;
        if (m_vx < 0) begin
            if (m_x >= 16 && nx <= 15 && covers(pl)) begin
                nx  = 16;
                nvx = SPX;
            end else if (nx <= 0) begin
                right_scores = 1;
            end
        end else begin
            if (m_x + BALL - 1 <= 624 && nx + BALL - 1 >= 625 && covers(pr)) begin
                nx  = 625 - BALL;
                nvx = -SPX;
            end else if (nx + BALL >= 640) begin
                left_scores = 1;
            end
        end

        if (left_scores || right_scores) begin
            if (left_scores) m_sl++;
            else m_sr++;
            if (m_sl == WIN || m_sr == WIN) begin
                m_state = M_OVER;
                m_vis   = 0;
            end else begin
                m_state    = M_SERVE;
                m_x        = 318;
                m_y        = 238;
                m_vx       = left_scores ? SPX : -SPX;
                m_vy       = m_serve_vy;
                m_serve_vy = -m_serve_vy;
                m_cnt      = SERVES - 1;
            end
        end else begin
            m_x  = nx;
            m_y  = ny;
            m_vx = nvx;
            m_vy = nvy;
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.x   = m_x;
        e.y   = m_y;
        e.vis = m_vis;
        e.sl  = m_sl;
        e.sr  = m_sr;
        e.go  = (m_state == M_OVER) ? 1 : 0;
        exp_q.push_back(e);
    endfunction

    function automatic int paddle_pos(int mode, int fixed_val);
        case (mode)
            TRACK:     return m_y + 2;
            RAND:      return int'($urandom_range(0, 511));
            EDGE_HIT:  return m_y + BALL + PH - 2;
            EDGE_MISS: return m_y + BALL + PH - 1;
            default:   return fixed_val;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Checker and monitor
    // ---------------------------------------------------------------------
    task automatic check(input string name, input exp_t e);
        total++;
        if (ball_x !== 10'(e.x) || ball_y !== 9'(e.y) || ball_visible !== 1'(e.vis) ||
            score_l !== 4'(e.sl) || score_r !== 4'(e.sr) || game_over !== 1'(e.go)) begin
            bad++;
            $display("FAIL %s t=%0t: got x=%0d y=%0d vis=%0b sl=%0d sr=%0d go=%0b, want x=%0d y=%0d vis=%0d sl=%0d sr=%0d go=%0d",
                     name, $time, ball_x, ball_y, ball_visible, score_l, score_r, game_over,
                     e.x, e.y, e.vis, e.sl, e.sr, e.go);
        end
    endtask

    logic ev = 1'b0;
    always @(posedge clk) ev <= frame_tick | start | rst;

    exp_t cur;
    bit   have_exp = 0;

    always @(negedge clk) begin
        if (ev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty t=%0t: got no queued entry, want one", $time);
            end else begin
                cur = exp_q.pop_front();
                have_exp = 1;
                check("event", cur);
            end
        end else if (have_exp) begin
            check("hold", cur);
        end
    end

    // ---------------------------------------------------------------------
    // Driver
    // ---------------------------------------------------------------------
    task automatic cycle(input bit tick, input bit st, input bit r, input int pl, input int pr);
        @(negedge clk);
        rst        = r;
        frame_tick = tick;
        start      = st;
        pos_l      = 9'(pl);
        pos_r      = 9'(pr);
        if (r) begin
            model_reset();
        end else if (m_state == M_OVER) begin
            if (st) model_restart();
        end else if (tick) begin
            model_tick(pl, pr);
        end
        if (r || tick || st) push_expected();
    endtask

    task automatic idle(input bit noise);
        bit st;
        st = noise && ($urandom_range(0, 7) == 0);
        cycle(0, st, 0, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
    endtask

    task automatic run_ticks(input int n, input int gap, input int ml, input int mr,
                             input int fl, input int fr, input bit noise, input bit until_over);
        for (int i = 0; i < n; i++) begin
            if (until_over && m_state == M_OVER) break;
            for (int g = 0; g < gap; g++) idle(noise);
            cycle(1, 0, 0, paddle_pos(ml, fl), paddle_pos(mr, fr));
        end
    endtask

    initial begin
        model_reset();
        // Reset, then the serve countdown and first move with long quiet gaps.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        run_ticks(61, 20, TRACK, TRACK, 0, 0, 0, 0);
        // Long rally: both paddles track, ball reaches the bottom wall.
        run_ticks(600, 2, TRACK, TRACK, 0, 0, 0, 0);
        // Reset mid-flight.
        cycle(0, 0, 1, 0, 0);
        // Right paddle parked far away: left player scores, then re-serve.
        run_ticks(230, 1, TRACK, FIXED, 0, 40, 0, 0);
        // Left paddle exactly touching the ball's bottom row: bounces.
        run_ticks(500, 1, EDGE_HIT, TRACK, 0, 0, 0, 0);
        // Left paddle one row short: right player scores.
        run_ticks(400, 1, EDGE_MISS, TRACK, 0, 0, 0, 0);
        // Random paddles until somebody wins.
        run_ticks(8000, 1, RAND, RAND, 0, 0, 0, 1);
        // Game over: ticks must not move anything.
        run_ticks(10, 1, RAND, RAND, 0, 0, 0, 0);
        // Restart, then play with stray start pulses that must be ignored.
        cycle(0, 1, 0, 0, 0);
        run_ticks(300, 2, RAND, TRACK, 0, 0, 1, 0);
        cycle(0, 0, 1, 0, 0);
        run_ticks(5, 1, TRACK, TRACK, 0, 0, 0, 0);
        repeat (3) idle(0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
